// File: rtl/rob_retire_if.sv
// Head-of-ROB commit bus: head entry fields and store handshake in, commit
// pulses, victim bypass and statistics out.
interface rob_retire_if #(
    parameter int TAG_W  = 5,
    parameter int WORD_W = 32
);
    logic              head_valid;
    logic              head_ready;
    logic [TAG_W-1:0]  head_tag;
    logic [4:0]        head_rd;
    logic [WORD_W-1:0] head_value;
    logic              head_regwr;
    logic              head_store;
    logic              head_load;
    logic              head_ecall;
    logic              head_unsupported;
    logic [TAG_W-1:0]  map_tag_rd;

    logic              store_req;
    logic              store_ack;
    logic              rob_pop;
    logic              lsq_pop;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [WORD_W-1:0] rf_wdata;
    logic              map_clear;
    logic [4:0]        victim_regstr;
    logic [WORD_W-1:0] victim_value;
    logic              halted;
    logic [31:0]       retired_count;
    logic [31:0]       store_stall_cycles;

    modport master (
        output head_valid, head_ready, head_tag, head_rd, head_value,
               head_regwr, head_store, head_load, head_ecall,
               head_unsupported, map_tag_rd, store_ack,
        input  store_req, rob_pop, lsq_pop, rf_we, rf_waddr, rf_wdata,
               map_clear, victim_regstr, victim_value, halted,
               retired_count, store_stall_cycles
    );

    modport slave (
        input  head_valid, head_ready, head_tag, head_rd, head_value,
               head_regwr, head_store, head_load, head_ecall,
               head_unsupported, map_tag_rd, store_ack,
        output store_req, rob_pop, lsq_pop, rf_we, rf_waddr, rf_wdata,
               map_clear, victim_regstr, victim_value, halted,
               retired_count, store_stall_cycles
    );
endinterface

// File: rtl/rob_retire.sv
// In-order commit at the ROB head: one retirement per cycle, store drain
// handshake, victim bypass register, ecall halt. Optional RETIRE_STATS_EN counters.
module rob_retire #(
    parameter int ROB_SIZE = 16,
    parameter int NUM_REGS = 32,
    parameter int WORD_W   = 32,
    parameter int TAG_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    rob_retire_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        STORE_WAIT = 2'd1,
        HALT       = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [TAG_W-1:0]  head_tag_w;
    logic [TAG_W-1:0]  map_tag_w;
    logic [WORD_W-1:0] head_value_w;
    logic              rd_writable;
    logic              tag_real;

    logic do_pop;
    logic do_lsq_pop;
    logic do_we;
    logic do_map_clear;
    logic do_store_req;

    logic [4:0]        victim_rd_q;
    logic [WORD_W-1:0] victim_val_q;

    assign head_tag_w   = bus.head_tag;
    assign map_tag_w    = bus.map_tag_rd;
    assign head_value_w = bus.head_value;

    // x0 is never written; tag 0 means "no producer" and must not match a map entry.
    assign rd_writable = (bus.head_rd != 5'd0) && (int'(bus.head_rd) < NUM_REGS);
    assign tag_real    = (head_tag_w != '0) && (int'(head_tag_w) <= ROB_SIZE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        do_pop       = 1'b0;
        do_lsq_pop   = 1'b0;
        do_we        = 1'b0;
        do_map_clear = 1'b0;
        do_store_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.head_valid && bus.head_ready) begin
                    if (bus.head_unsupported) begin
                        do_pop = 1'b1;
                    end else if (bus.head_ecall) begin
                        do_pop  = 1'b1;
                        state_d = HALT;
                    end else if (bus.head_store) begin
                        do_store_req = 1'b1;
                        state_d      = STORE_WAIT;
                    end else begin
                        do_pop       = 1'b1;
                        do_lsq_pop   = bus.head_load;
                        do_we        = bus.head_regwr && rd_writable;
                        // A younger in-flight producer of rd keeps its mapping.
                        do_map_clear = bus.head_regwr && rd_writable && tag_real &&
                                       (map_tag_w == head_tag_w);
                    end
                end
            end
            STORE_WAIT: begin
                if (bus.store_ack) begin
                    do_pop     = 1'b1;
                    do_lsq_pop = 1'b1;
                    state_d    = IDLE;
                end else begin
                    do_store_req = 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            victim_rd_q  <= '0;
            victim_val_q <= '0;
        end else if (do_we) begin
            victim_rd_q  <= bus.head_rd;
            victim_val_q <= head_value_w;
        end else begin
            victim_rd_q  <= '0;
            victim_val_q <= '0;
        end
    end

    // Every output, combinational ones included, reads as zero while reset is low.
    assign bus.rob_pop       = reset && do_pop;
    assign bus.lsq_pop       = reset && do_lsq_pop;
    assign bus.rf_we         = reset && do_we;
    assign bus.map_clear     = reset && do_map_clear;
    assign bus.store_req     = reset && do_store_req;
    assign bus.rf_waddr      = (reset && do_we) ? bus.head_rd : 5'd0;
    assign bus.rf_wdata      = (reset && do_we) ? head_value_w : '0;
    assign bus.victim_regstr = reset ? victim_rd_q : 5'd0;
    assign bus.victim_value  = reset ? victim_val_q : '0;
    assign bus.halted        = reset && (state_q == HALT);

`ifdef RETIRE_STATS_EN
    logic [31:0] retired_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (do_pop) begin
                retired_q <= retired_q + 32'd1;
            end
            if (state_q == STORE_WAIT) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign bus.retired_count      = reset ? retired_q : 32'd0;
    assign bus.store_stall_cycles = reset ? stall_q : 32'd0;
`else
    assign bus.retired_count      = 32'd0;
    assign bus.store_stall_cycles = 32'd0;
`endif
endmodule

// File: doc/rob_retire.md
Name: rob_retire

Overview:
Commit stage at the ROB head, consuming the entries the dispatch scheduler writes. It retires at most one in-order entry per cycle. A retirement writes the register file, clears the matching map-table entry, and drains committed stores through a memory handshake. The retired register/value is published for one cycle as the victim so dispatch can bypass it. ECALL halts commit.

Parameters:
ROB_SIZE, 16, ROB entries; tags are 1..ROB_SIZE, and 0 means "no tag"
NUM_REGS, 32, architectural registers; register 0 is hardwired zero
WORD_W, 32, data word width
TAG_W, 5, tag width; must hold ROB_SIZE

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
head_valid  in  1  ROB non-empty (rob_count > 0)
head_ready  in  1  head entry result ready
head_tag  in  TAG_W  tag of head entry (1-based)
head_rd  in  5  destination register
head_value  in  WORD_W  result / store data
head_regwr  in  1  entry writes rd
head_store  in  1  entry is a store (memwr)
head_load  in  1  entry is a load (memtoreg)
head_ecall  in  1  ecall control bit
head_unsupported  in  1  unsupported-instruction bit
map_tag_rd  in  TAG_W  current map-table tag for head_rd
store_req  out  1  commit head store to memory
store_ack  in  1  memory accepted store
rob_pop  out  1  advance ROB head (one-cycle pulse)
lsq_pop  out  1  advance LSQ head (one-cycle pulse)
rf_we  out  1  register-file write enable
rf_waddr  out  5  write address
rf_wdata  out  WORD_W  write data
map_clear  out  1  clear map_table[rf_waddr] (tag := 0, in_rob := 0)
victim_regstr  out  5  register retired last cycle; 0 = none
victim_value  out  WORD_W  its value
halted  out  1  ecall retired; commit frozen
retired_count  out  32  entries retired (RETIRE_STATS_EN)
store_stall_cycles  out  32  cycles spent in STORE_WAIT (RETIRE_STATS_EN)

Behaviour:
- The FSM states are IDLE, STORE_WAIT and HALT. `reset` is sampled on the rising edge of `clk`; while it is low, the state goes to IDLE.
- While `reset` is low, all outputs are 0. This includes the combinational ones.
- "Retire" means `head_valid && head_ready` in IDLE.
- rob_pop, lsq_pop, rf_we, map_clear and store_req are combinational from state and head inputs. They assert in the same cycle as the retirement decision, with zero latency.
- IDLE, `head_unsupported`: rob_pop = 1 only. No RF or map update. Stay in IDLE.
- IDLE, `head_ecall`: rob_pop = 1, then go to HALT.
- IDLE, `head_store`: store_req = 1 with no pop, then go to STORE_WAIT.
- IDLE, `head_load`: rob_pop = 1 and lsq_pop = 1. The load also performs the register write below.
- IDLE, normal entry with `head_regwr` and head_rd != 0:
  - rf_we = 1, rf_waddr = head_rd, rf_wdata = head_value.
  - map_clear = 1 only if map_tag_rd == head_tag. A younger producer keeps its mapping.
- IDLE, normal entry with head_rd == 0: no RF write and no map_clear. rob_pop still pulses.
- IDLE, non-ready or empty head: all pulses are 0.
- STORE_WAIT: store_req is held at 1. On store_ack: rob_pop = 1 and lsq_pop = 1 in the same cycle, store_req = 0 in that cycle, then go to IDLE. No register write.
- store_ack outside STORE_WAIT is ignored.
- HALT: all pulses are 0 and halted = 1. The state is sticky until reset.
- Victim is registered. The cycle after an rf_we retirement, victim_regstr and victim_value equal the written rd and value. On every other cycle both are 0. Victim is never held stale for more than one cycle.
- Head inputs must be stable while in STORE_WAIT. That is a checker property; the RTL need not enforce it.
- Reset in STORE_WAIT: go to IDLE and drop store_req; the store is not popped.
- A simultaneous head_ecall and head_unsupported is treated as unsupported (unsupported has priority).

Optional Feature:
RETIRE_STATS_EN
- Defined: retired_count increments by 1 on every rob_pop. store_stall_cycles increments on every cycle in STORE_WAIT. Both are 32-bit wrapping counters, reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Reset low for 2 cycles with head_valid = 1 and head_ready = 1 -> all outputs 0. After release, the first retirement occurs in the next cycle.
- Ready ALU entry (tag 3, rd 5, value 0xDEADBEEF, map_tag_rd 3) -> same cycle: rob_pop = 1, rf_we = 1, rf_waddr = 5, map_clear = 1. Next cycle: victim_regstr = 5, victim_value = 0xDEADBEEF. Cycle after that: victim_regstr = 0.
- Same entry with map_tag_rd = 7 -> rf_we = 1, map_clear = 0.
- Store with store_ack delayed 3 cycles -> store_req held for 4 cycles, then rob_pop = 1 and lsq_pop = 1 together on the ack cycle. store_stall_cycles = 4 with RETIRE_STATS_EN.
- head_ecall ready -> rob_pop pulses once, then halted = 1. Later ready entries are never popped. Reset clears halted.
- Unsupported entry followed by an rd = 0 entry -> two rob_pop pulses, no rf_we, no map_clear. retired_count = 2.
